lsu_mem_if: RTL and testbench

Parametrised load/store interface between the execute stage and the synchronous data memory port. It is the next generation of the core's data-memory block. It supports byte, half, word and (at DATA_WIDTH=64) doubleword accesses. Store data is lane-aligned with strobes; load data is extracted and sign/zero-extended into a registered, stall-holding result. Misaligned accesses are detected and blocked before they reach memory.

---
 rtl/lsu_mem_if_if.sv | 50 +++++
 rtl/lsu_mem_if.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_if.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if_if.sv
// lsu_mem_if_if -- bundles the execute-stage request, the data-memory port and
// the load result of lsu_mem_if into one interface.
//   slave  : the load/store unit (requests in, memory port and result out)
//   master : the requester/memory side (drives requests and read data)
// Parameters must match the lsu_mem_if instance that uses this interface.
interface lsu_mem_if_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    // execute-stage request
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic                  stall_en;

    // synchronous data-memory port
    logic [DATA_WIDTH-1:0] data_mem_read_data;
    logic                  data_mem_write_en;
    logic [ADDR_WIDTH-1:0] data_mem_write_addr;
    logic [DATA_WIDTH-1:0] data_mem_write_data;
    logic [NB-1:0]         data_mem_strobe;
    logic                  data_mem_read_en;
    logic [ADDR_WIDTH-1:0] data_mem_read_addr;

    // load result towards the register file
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  misalign_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
               stall_en, data_mem_read_data,
        output data_mem_write_en, data_mem_write_addr, data_mem_write_data,
               data_mem_strobe, data_mem_read_en, data_mem_read_addr,
               rd_data, rd_valid, misalign_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
               stall_en, data_mem_read_data,
        input  data_mem_write_en, data_mem_write_addr, data_mem_write_data,
               data_mem_strobe, data_mem_read_en, data_mem_read_addr,
               rd_data, rd_valid, misalign_err
    );
endinterface

// File: rtl/lsu_mem_if.sv
// lsu_mem_if -- load/store unit between the execute stage and a synchronous
// data memory. Stores go out combinationally with lane-shifted data and byte
// strobes; loads issue a read, then extract and sign/zero-extend the returned
// lane into a registered result that holds while the pipeline is stalled.
// Misaligned (or illegal dword on a 32-bit path) requests never reach memory
// and raise a one-cycle misalign_err.
// Ports:
//   mem_clk  : clock
//   mem_rst  : asynchronous active-low reset
//   bus      : lsu_mem_if_if.slave (request, memory port, load result)
module lsu_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          mem_clk,
    input  logic          mem_rst,
    lsu_mem_if_if.slave   bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic { IDLE, PEND } pend_state_t;

    pend_state_t state, state_nxt;

    logic [OFS-1:0]        offset;
    logic [OFS+2:0]        wr_shamt;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic                  aligned;
    logic [NB-1:0]         size_mask;
    logic                  req_go;
    logic                  accept;
    logic                  reject;
    logic                  load_go;

    // load-pending stage
    logic [OFS-1:0]        offset_r;
    logic [1:0]            size_r;
    logic                  uns_r;

    // extraction
    logic [OFS+2:0]        rd_shamt;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] lane_msk;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] ext_data;

    assign offset       = bus.req_addr[OFS-1:0];
    assign wr_shamt     = {offset, 3'b000};
    assign aligned_addr = bus.req_addr & ~ADDR_WIDTH'(NB - 1);

    always_comb begin
        aligned   = 1'b0;
        size_mask = '0;
        case (bus.req_size)
            2'd0: begin
                aligned   = 1'b1;
                size_mask = NB'(1);
            end
            2'd1: begin
                aligned   = ~bus.req_addr[0];
                size_mask = NB'(2'b11);
            end
            2'd2: begin
                aligned   = (bus.req_addr[1:0] == 2'b00);
                size_mask = NB'(4'hF);
            end
            default: begin
                // dword only exists on the 64-bit data path
                aligned   = (DATA_WIDTH == 64) && (bus.req_addr[2:0] == 3'b000);
                size_mask = '1;
            end
        endcase
    end

    // mem_rst gates acceptance so every combinational output is 0 in reset
    assign req_go  = mem_rst & bus.req_valid & ~bus.stall_en;
    assign accept  = req_go & aligned;
    assign reject  = req_go & ~aligned;
    assign load_go = accept & ~bus.req_we;

    always_comb begin
        bus.data_mem_write_en   = 1'b0;
        bus.data_mem_write_addr = '0;
        bus.data_mem_write_data = '0;
        bus.data_mem_strobe     = '0;
        bus.data_mem_read_en    = 1'b0;
        bus.data_mem_read_addr  = '0;
        if (accept && bus.req_we) begin
            bus.data_mem_write_en   = 1'b1;
            bus.data_mem_write_addr = aligned_addr;
            bus.data_mem_write_data = bus.req_wdata << wr_shamt;
            bus.data_mem_strobe     = size_mask << offset;
        end
        if (load_go) begin
            bus.data_mem_read_en   = 1'b1;
            bus.data_mem_read_addr = aligned_addr;
        end
    end

    // load-pending state machine
    always_ff @(posedge mem_clk or negedge mem_rst) begin
        if (!mem_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (load_go) state_nxt = PEND;
    end

    always_ff @(posedge mem_clk or negedge mem_rst) begin
        if (!mem_rst) begin
            offset_r <= '0;
            size_r   <= '0;
            uns_r    <= 1'b0;
        end else if (load_go) begin
            offset_r <= offset;
            size_r   <= bus.req_size;
            uns_r    <= bus.req_unsigned;
        end
    end

    // Extension is done by masking the lane and OR-ing in the inverted mask
    // when the access is signed and negative.
    assign rd_shamt = {offset_r, 3'b000};
    assign shifted  = bus.data_mem_read_data >> rd_shamt;

    always_comb begin
        lane_msk = '1;
        sign_bit = shifted[DATA_WIDTH-1];
        case (size_r)
            2'd0: begin
                lane_msk = DATA_WIDTH'(8'hFF);
                sign_bit = shifted[7];
            end
            2'd1: begin
                lane_msk = DATA_WIDTH'(16'hFFFF);
                sign_bit = shifted[15];
            end
            2'd2: begin
                lane_msk = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: ;
        endcase
        ext_data = (shifted & lane_msk) | ((sign_bit && !uns_r) ? ~lane_msk : '0);
    end

    // Memory returns data unconditionally, so PEND always loads the result
    // even when stalled; otherwise a stall holds it.
    always_ff @(posedge mem_clk or negedge mem_rst) begin
        if (!mem_rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else if (state == PEND) begin
            bus.rd_data  <= ext_data;
            bus.rd_valid <= 1'b1;
        end else if (!bus.stall_en) begin
            bus.rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge mem_clk or negedge mem_rst) begin
        if (!mem_rst) bus.misalign_err <= 1'b0;
        else          bus.misalign_err <= reject;
    end
endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    lsu_mem_if_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
    lsu_mem_if_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

    lsu_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .mem_clk (clk),
        .mem_rst (rst),
        .bus     (bus32)
    );

    lsu_mem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .mem_clk (clk),
        .mem_rst (rst),
        .bus     (bus64)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid, we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata, mdata;
        logic        e_we, e_re, e_err;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] val;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    task automatic add(input logic valid, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mdata, input logic e_we, input logic e_re,
                       input logic e_err, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [3:0] e_strb,
                       input logic [31:0] e_rd);
        vec_t v;
        v.valid = valid; v.we = we; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.mdata = mdata;
        v.e_we = e_we; v.e_re = e_re; v.e_err = e_err;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_strb = e_strb; v.e_rd = e_rd;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++)
            if (strb[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic drive32(input logic valid, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic stall);
        bus32.req_valid    = valid;
        bus32.req_we       = we;
        bus32.req_size     = size;
        bus32.req_unsigned = uns;
        bus32.req_addr     = addr;
        bus32.req_wdata    = wdata;
        bus32.stall_en     = stall;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] junk;
        junk = 32'h5A5A_5A5A;

        // valid, we, size, uns, addr, wdata, mdata, e_we, e_re, e_err, e_addr, e_wdata, e_strb, e_rd
        add(1, 1, 0, 0, 32'h1003, 32'h0000_00A5, junk,            1, 0, 0, 32'h1000, 32'hA500_0000, 4'b1000, 0);
        add(1, 0, 0, 0, 32'h1003, 0,             32'hA500_0000,   0, 1, 0, 32'h1000, 0, 0, 32'hFFFF_FFA5);
        add(1, 0, 0, 1, 32'h1003, 0,             32'hA500_0000,   0, 1, 0, 32'h1000, 0, 0, 32'h0000_00A5);
        add(1, 0, 1, 0, 32'h2002, 0,             32'h8001_1234,   0, 1, 0, 32'h2000, 0, 0, 32'hFFFF_8001);
        add(1, 0, 2, 0, 32'h2004, 0,             32'hDEAD_BEEF,   0, 1, 0, 32'h2004, 0, 0, 32'hDEAD_BEEF);
        add(1, 0, 2, 0, 32'h1002, 0,             junk,            0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 3, 0, 32'h0000, 0,             junk,            0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 32'h1002, 32'h0000_BEEF, junk,            1, 0, 0, 32'h1000, 32'hBEEF_0000, 4'b1100, 0);
        add(1, 1, 2, 0, 32'h3000, 32'h1234_5678, junk,            1, 0, 0, 32'h3000, 32'h1234_5678, 4'b1111, 0);
        add(1, 0, 1, 1, 32'h2002, 0,             32'h8001_1234,   0, 1, 0, 32'h2000, 0, 0, 32'h0000_8001);
        add(1, 0, 0, 0, 32'h4001, 0,             32'h0000_7F00,   0, 1, 0, 32'h4000, 0, 0, 32'h0000_007F);
        add(1, 1, 1, 0, 32'h1001, 32'h0000_1111, junk,            0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 32'h4000, 0,             32'h0000_FFFE,   0, 1, 0, 32'h4000, 0, 0, 32'hFFFF_FFFE);
        add(0, 0, 0, 0, 0, 0, junk, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, junk, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, junk, 0, 0, 0, 0, 0, 0, 0);

        bus64.req_valid = 0; bus64.req_we = 0; bus64.req_size = 0; bus64.req_unsigned = 0;
        bus64.req_addr = 0; bus64.req_wdata = 0; bus64.stall_en = 0; bus64.data_mem_read_data = 0;
        bus32.data_mem_read_data = 0;

        // reset: all outputs 0 even with a legal store presented
        drive32(1, 1, 2, 0, 32'h10, 32'hFFFF_FFFF, 0);
        #2;
        chk("rst_we",     bus32.data_mem_write_en,   0);
        chk("rst_wdata",  bus32.data_mem_write_data, 0);
        chk("rst_strobe", bus32.data_mem_strobe,     0);
        chk("rst_waddr",  bus32.data_mem_write_addr, 0);
        chk("rst_rd",     {bus32.rd_valid, bus32.rd_data, bus32.misalign_err}, 0);
        @(negedge clk);
        drive32(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // table-driven run with load scoreboard
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus32.data_mem_read_data = (i > 0) ? tbl[i-1].mdata : 32'h0;
            drive32(tbl[i].valid, tbl[i].we, tbl[i].size, tbl[i].uns,
                    tbl[i].addr, tbl[i].wdata, 0);
            #1;
            chk($sformatf("v%0d_write_en", i), bus32.data_mem_write_en, tbl[i].e_we);
            chk($sformatf("v%0d_read_en", i),  bus32.data_mem_read_en,  tbl[i].e_re);
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_write_addr", i), bus32.data_mem_write_addr, tbl[i].e_addr);
                chk($sformatf("v%0d_strobe", i),     bus32.data_mem_strobe,     tbl[i].e_strb);
                chk($sformatf("v%0d_write_data", i),
                    bus32.data_mem_write_data & lane_mask(tbl[i].e_strb), tbl[i].e_wdata);
            end
            if (tbl[i].e_re) begin
                sb_t e;
                chk($sformatf("v%0d_read_addr", i), bus32.data_mem_read_addr, tbl[i].e_addr);
                e.due = i + 2;
                e.val = tbl[i].e_rd;
                sbq.push_back(e);
            end
            chk($sformatf("v%0d_misalign_err", i), bus32.misalign_err,
                (i > 0) ? tbl[i-1].e_err : 1'b0);
            if (sbq.size() > 0 && sbq[0].due == i) begin
                chk($sformatf("v%0d_rd_valid", i), bus32.rd_valid, 1);
                chk($sformatf("v%0d_rd_data", i),  bus32.rd_data,  sbq[0].val);
                void'(sbq.pop_front());
            end else begin
                chk($sformatf("v%0d_rd_valid_idle", i), bus32.rd_valid, 0);
            end
        end
        chk("scoreboard_empty", sbq.size(), 0);

        // stall hold: lw at T, stall with a (misaligned) request held T+1..T+3
        @(negedge clk);
        bus32.data_mem_read_data = junk;
        drive32(1, 0, 2, 0, 32'h5000, 0, 0);
        #1 chk("stall_T_read_en", bus32.data_mem_read_en, 1);
        @(negedge clk);
        bus32.data_mem_read_data = 32'hCAFE_F00D;
        drive32(1, 0, 2, 0, 32'h6002, 0, 1);
        #1 chk("stall_T1_enables", {bus32.data_mem_read_en, bus32.data_mem_write_en}, 0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            bus32.data_mem_read_data = junk;
            #1;
            chk($sformatf("stall_T%0d_enables", k), {bus32.data_mem_read_en, bus32.data_mem_write_en}, 0);
            chk($sformatf("stall_T%0d_rd_valid", k), bus32.rd_valid, 1);
            chk($sformatf("stall_T%0d_rd_data", k), bus32.rd_data, 32'hCAFE_F00D);
            chk($sformatf("stall_T%0d_no_err", k), bus32.misalign_err, 0);
        end
        @(negedge clk);
        drive32(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("stall_release_rd_valid", bus32.rd_valid, 0);
        chk("stall_release_rd_data_kept", bus32.rd_data, 32'hCAFE_F00D);

        // reset during an in-flight load
        @(negedge clk);
        drive32(1, 0, 2, 0, 32'h7000, 0, 0);
        #1 chk("rstload_read_en", bus32.data_mem_read_en, 1);
        @(negedge clk);
        drive32(1, 1, 2, 0, 32'h10, 32'hFFFF_FFFF, 0);
        bus32.data_mem_read_data = 32'h1111_1111;
        rst = 1'b0;
        #1;
        chk("rstload_we",   bus32.data_mem_write_en, 0);
        chk("rstload_re",   bus32.data_mem_read_en,  0);
        chk("rstload_bus",  {bus32.data_mem_write_addr, bus32.data_mem_read_addr}, 0);
        chk("rstload_wd",   {bus32.data_mem_write_data, bus32.data_mem_strobe}, 0);
        chk("rstload_rd",   {bus32.rd_valid, bus32.rd_data, bus32.misalign_err}, 0);
        @(negedge clk);
        drive32(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk($sformatf("rstload_after%0d_rd_valid", k), bus32.rd_valid, 0);
        end

        // 64-bit instance: sd, lw at upper word, misaligned ld
        @(negedge clk);
        bus64.req_valid = 1; bus64.req_we = 1; bus64.req_size = 3;
        bus64.req_addr = 32'h8; bus64.req_wdata = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("sd_write_en",   bus64.data_mem_write_en,   1);
        chk("sd_write_addr", bus64.data_mem_write_addr, 32'h8);
        chk("sd_strobe",     bus64.data_mem_strobe,     8'hFF);
        chk("sd_write_data", bus64.data_mem_write_data, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        bus64.req_we = 0; bus64.req_size = 2; bus64.req_addr = 32'h1004;
        #1;
        chk("lw64_read_en",   bus64.data_mem_read_en,   1);
        chk("lw64_read_addr", bus64.data_mem_read_addr, 32'h1000);
        @(negedge clk);
        bus64.req_valid = 0;
        bus64.data_mem_read_data = 64'hDEAD_BEEF_0000_0000;
        @(negedge clk);
        bus64.data_mem_read_data = 64'h0;
        #1;
        chk("lw64_rd_valid", bus64.rd_valid, 1);
        chk("lw64_rd_data",  bus64.rd_data,  64'hFFFF_FFFF_DEAD_BEEF);
        @(negedge clk);
        bus64.req_valid = 1; bus64.req_size = 3; bus64.req_addr = 32'h4;
        #1 chk("ld64_mis_read_en", bus64.data_mem_read_en, 0);
        @(negedge clk);
        bus64.req_valid = 0;
        #1 chk("ld64_mis_err", bus64.misalign_err, 1);
        @(negedge clk);
        #1 chk("ld64_mis_err_drop", bus64.misalign_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
